// File: rtl/md_pkg.sv
// Shared state encoding and default sizing for the multiply/divide sequencer.
package md_pkg;

  localparam int unsigned MD_ITERS = 32;
  localparam int unsigned MD_CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_EXC  = 3'd4
  } md_state_e;

  // States in which the front of the pipeline must be held.
  function automatic logic st_busy(input md_state_e s);
    return (s == ST_LOAD) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Decode-stage request / datapath control bundle between the pipeline and the sequencer.
interface md_sequencer_if import md_pkg::*; #(
  parameter int unsigned CNT_W = MD_CNT_W
) ();

  logic             start_mult;
  logic             start_div;
  logic             divisor_zero;
  logic             flush;
  logic             md_load;
  logic             md_step;
  logic             md_is_div;
  logic [CNT_W-1:0] iter;
  logic             stall;
  logic             result_valid;
  logic             exception;

  modport master (
    output start_mult, start_div, divisor_zero, flush,
    input  md_load, md_step, md_is_div, iter, stall, result_valid, exception
  );

  modport slave (
    input  start_mult, start_div, divisor_zero, flush,
    output md_load, md_step, md_is_div, iter, stall, result_valid, exception
  );

endinterface

// File: rtl/md_iter_counter.sv
// Iteration counter: synchronous clear, count enable, wraps to zero after ITERS-1.
module md_iter_counter import md_pkg::*; #(
  parameter int unsigned ITERS = MD_ITERS,
  parameter int unsigned CNT_W = MD_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  logic [CNT_W-1:0] count_q;

  // Iteration index; clear wins over enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      if (count_q == LAST) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == LAST);

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide control FSM: sequences load/step strobes and
// holds the front of the pipeline until the iterative datapath finishes.
module md_sequencer import md_pkg::*; #(
  parameter int unsigned ITERS = MD_ITERS,
  parameter int unsigned CNT_W = MD_CNT_W
) (
  input  logic           clock,
  input  logic           reset_n,
  md_sequencer_if.slave  bus
);

  md_state_e        state_q;
  logic             is_div_q;
  logic             cnt_clear_s;
  logic             cnt_en_s;
  logic             cnt_tc_s;
  logic [CNT_W-1:0] iter_s;
  logic             start_any_s;

  md_iter_counter #(
    .ITERS (ITERS),
    .CNT_W (CNT_W)
  ) u_iter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (cnt_clear_s),
    .enable_i (cnt_en_s),
    .count_o  (iter_s),
    .tc_o     (cnt_tc_s)
  );

  // Counter only advances in RUN; everywhere else it is held at zero.
  always_comb begin
    cnt_clear_s = 1'b1;
    cnt_en_s    = 1'b0;
    if (bus.flush) begin
      cnt_clear_s = 1'b1;
      cnt_en_s    = 1'b0;
    end else begin
      cnt_clear_s = (state_q != ST_RUN);
      cnt_en_s    = (state_q == ST_RUN);
    end
  end

  // Sequencer FSM and captured operation type; flush overrides everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
    end else if (bus.flush) begin
      state_q  <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_div) begin
            is_div_q <= 1'b1;
            state_q  <= bus.divisor_zero ? ST_EXC : ST_LOAD;
          end else if (bus.start_mult) begin
            is_div_q <= 1'b0;
            state_q  <= ST_LOAD;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_LOAD: state_q <= ST_RUN;
        ST_RUN:  state_q <= cnt_tc_s ? ST_DONE : ST_RUN;
        ST_DONE: state_q <= ST_IDLE;
        ST_EXC:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign start_any_s = bus.start_mult | bus.start_div;

  // Strobes come from the state register; a flush cycle masks them all.
  always_comb begin
    bus.md_load      = 1'b0;
    bus.md_step      = 1'b0;
    bus.result_valid = 1'b0;
    bus.exception    = 1'b0;
    if (bus.flush) begin
      bus.md_load      = 1'b0;
      bus.md_step      = 1'b0;
      bus.result_valid = 1'b0;
      bus.exception    = 1'b0;
    end else begin
      bus.md_load      = (state_q == ST_LOAD);
      bus.md_step      = (state_q == ST_RUN);
      bus.result_valid = (state_q == ST_DONE) || (state_q == ST_EXC);
      bus.exception    = (state_q == ST_EXC);
    end
  end

  // A start in IDLE stalls in its own cycle so decode holds the instruction.
  always_comb begin
    bus.stall = 1'b0;
    if (!reset_n) begin
      bus.stall = 1'b0;
    end else if (st_busy(state_q)) begin
      bus.stall = 1'b1;
    end else begin
      bus.stall = (state_q == ST_IDLE) && start_any_s && !bus.flush;
    end
  end

  assign bus.md_is_div = is_div_q;
  assign bus.iter      = iter_s;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with a cycle-offset reference model.
module tb_md_sequencer;
  import md_pkg::*;

  localparam int ITERS = 32;
  localparam int CNT_W = 5;

  logic clock = 1'b0;
  logic reset_n;

  md_sequencer_if #(.CNT_W(CNT_W)) bus ();

  md_sequencer #(.ITERS(ITERS), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted operation is described only by its start
  // cycle and kind; every expected output is a function of the offset.
  bit m_act = 1'b0;
  bit m_exc = 1'b0;
  bit m_div = 1'b0;
  int m_st  = 0;

  // Per-scenario statistics observed from the DUT.
  int base, first_load, n_step, n_valid, n_exc, n_stall, valid_at, last_stall;

  task automatic clear_stats();
    base       = cyc;
    first_load = -1;
    n_step     = 0;
    n_valid    = 0;
    n_exc      = 0;
    n_stall    = 0;
    valid_at   = -1;
    last_stall = -1;
  endtask

  always @(negedge clock) begin
    int off;
    bit normal, in_load, in_run, in_fin, nonidle, req;
    int e_iter;
    if (!reset_n) begin
      m_act = 1'b0;
      m_div = 1'b0;
      check("rst_load",  32'(bus.md_load),      32'd0);
      check("rst_step",  32'(bus.md_step),      32'd0);
      check("rst_valid", 32'(bus.result_valid), 32'd0);
      check("rst_exc",   32'(bus.exception),    32'd0);
      check("rst_isdiv", 32'(bus.md_is_div),    32'd0);
      check("rst_iter",  32'(bus.iter),         32'd0);
      check("rst_stall", 32'(bus.stall),        32'd0);
    end else begin
      off     = cyc - m_st;
      normal  = m_act && !m_exc;
      in_load = normal && (off == 1);
      in_run  = normal && (off >= 2) && (off <= ITERS + 1);
      in_fin  = m_act && (m_exc ? (off == 1) : (off == ITERS + 2));
      nonidle = in_load || in_run || in_fin;
      req     = bus.start_mult || bus.start_div;
      e_iter  = in_run ? off - 2 : 0;
      check("load",  32'(bus.md_load),      32'(in_load && !bus.flush));
      check("step",  32'(bus.md_step),      32'(in_run && !bus.flush));
      check("valid", 32'(bus.result_valid), 32'(in_fin && !bus.flush));
      check("exc",   32'(bus.exception),    32'(in_fin && m_exc && !bus.flush));
      check("isdiv", 32'(bus.md_is_div),    32'(m_div));
      check("iter",  32'(bus.iter),         32'(e_iter));
      if (!bus.flush) check("stall", 32'(bus.stall), 32'(in_load || in_run || (!nonidle && req)));
      if (bus.flush) begin
        m_act = 1'b0;
      end else if (!nonidle && req) begin
        m_act = 1'b1;
        m_st  = cyc;
        m_exc = bus.start_div && bus.divisor_zero;
        m_div = bus.start_div;
      end
      if (bus.md_load && first_load < 0) first_load = cyc - base;
      if (bus.md_step) n_step++;
      if (bus.result_valid) begin
        n_valid++;
        valid_at = cyc - base;
      end
      if (bus.exception) n_exc++;
      if (bus.stall) begin
        n_stall++;
        last_stall = cyc - base;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.start_mult   = 1'b0;
    bus.start_div    = 1'b0;
    bus.divisor_zero = 1'b0;
    bus.flush        = 1'b0;
    clear_stats();
    tick(3);

    // Start held during reset must not stall.
    bus.start_mult = 1'b1;
    #2;
    check("stall_in_reset", 32'(bus.stall), 32'd0);

    // Multiply, start accepted on the first edge after release.
    clear_stats();
    reset_n = 1'b1;
    tick(1);
    bus.start_mult = 1'b0;
    tick(39);
    check("mul_first_load", 32'(first_load), 32'd1);
    check("mul_steps",      32'(n_step),     32'd32);
    check("mul_valid_at",   32'(valid_at),   32'd34);
    check("mul_n_valid",    32'(n_valid),    32'd1);
    check("mul_n_exc",      32'(n_exc),      32'd0);
    check("mul_n_stall",    32'(n_stall),    32'd34);
    check("mul_last_stall", 32'(last_stall), 32'd33);
    check("mul_isdiv",      32'(bus.md_is_div), 32'd0);

    // Divide by zero.
    clear_stats();
    bus.start_div    = 1'b1;
    bus.divisor_zero = 1'b1;
    tick(1);
    bus.start_div    = 1'b0;
    bus.divisor_zero = 1'b0;
    tick(4);
    check("dz_valid_at",   32'(valid_at),   32'd1);
    check("dz_n_exc",      32'(n_exc),      32'd1);
    check("dz_steps",      32'(n_step),     32'd0);
    check("dz_n_stall",    32'(n_stall),    32'd1);
    check("dz_last_stall", 32'(last_stall), 32'd0);
    check("dz_isdiv",      32'(bus.md_is_div), 32'd1);

    // Simultaneous starts: divide wins.
    clear_stats();
    bus.start_mult = 1'b1;
    bus.start_div  = 1'b1;
    tick(1);
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    tick(1);
    check("both_isdiv", 32'(bus.md_is_div), 32'd1);
    tick(38);
    check("both_valid_at", 32'(valid_at), 32'd34);
    check("both_steps",    32'(n_step),   32'd32);
    check("both_n_exc",    32'(n_exc),    32'd0);

    // Flush at cycle 10 of a divide, then a fresh multiply at cycle 12.
    clear_stats();
    bus.start_div = 1'b1;
    tick(1);
    bus.start_div = 1'b0;
    tick(9);
    bus.flush = 1'b1;
    #2;
    check("flush_step_masked", 32'(bus.md_step), 32'd0);
    tick(1);
    bus.flush = 1'b0;
    check("flush_iter",  32'(bus.iter),  32'd0);
    check("flush_stall", 32'(bus.stall), 32'd0);
    tick(1);
    bus.start_mult = 1'b1;
    tick(1);
    bus.start_mult = 1'b0;
    tick(40);
    check("flush_n_valid",  32'(n_valid),  32'd1);
    check("flush_valid_at", 32'(valid_at), 32'd46);
    check("flush_steps",    32'(n_step),   32'd40);

    // Starts during RUN and in DONE are ignored; the following IDLE start is taken.
    clear_stats();
    bus.start_mult = 1'b1;
    tick(1);
    bus.start_mult = 1'b0;
    tick(9);
    bus.start_mult = 1'b1;
    tick(1);
    bus.start_mult = 1'b0;
    tick(23);
    bus.start_mult = 1'b1;
    check("done_valid", 32'(bus.result_valid), 32'd1);
    tick(1);
    tick(1);
    bus.start_mult = 1'b0;
    check("ign_n_valid", 32'(n_valid), 32'd1);
    tick(36);
    check("b2b_n_valid",  32'(n_valid),  32'd2);
    check("b2b_valid_at", 32'(valid_at), 32'd69);
    check("b2b_steps",    32'(n_step),   32'd64);

    // Reset pulsed mid-multiply, then a divide right after release.
    clear_stats();
    bus.start_mult = 1'b1;
    tick(1);
    bus.start_mult = 1'b0;
    tick(14);
    reset_n = 1'b0;
    #1;
    check("arst_step",  32'(bus.md_step), 32'd0);
    check("arst_iter",  32'(bus.iter),    32'd0);
    check("arst_stall", 32'(bus.stall),   32'd0);
    tick(1);
    clear_stats();
    reset_n       = 1'b1;
    bus.start_div = 1'b1;
    tick(1);
    bus.start_div = 1'b0;
    tick(40);
    check("rel_first_load", 32'(first_load), 32'd1);
    check("rel_n_valid",    32'(n_valid),    32'd1);
    check("rel_valid_at",   32'(valid_at),   32'd34);
    check("rel_isdiv",      32'(bus.md_is_div), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
